// File: rtl/tap_freq_meter_pkg.sv
// rtl/tap_freq_meter_pkg.sv - shared types and constants for the tap frequency meter
package tap_freq_meter_pkg;

  localparam int WIN_UNIT = 64;
  localparam int CNT_W    = 8;
  localparam int WIN_W    = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Window counter preload: (gate+1)*WIN_UNIT - 1, so the last MEASURE cycle sees zero
  function automatic logic [WIN_W-1:0] win_reload(input logic [3:0] gate);
    return {gate, 6'(WIN_UNIT - 1)};
  endfunction

endpackage

// File: rtl/tap_freq_meter_if.sv
// rtl/tap_freq_meter_if.sv - control and result bundle of the tap frequency meter
interface tap_freq_meter_if;
  import tap_freq_meter_pkg::*;

  logic [1:0]       sel;
  logic [3:0]       gate_len;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (output sel, gate_len, start, input count, busy, done, ovf);
  modport slave  (input sel, gate_len, start, output count, busy, done, ovf);
endinterface

// File: rtl/tap_sync.sv
// rtl/tap_sync.sv - two-flop synchronizer with rising-edge detector for one tap
module tap_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise = s2_q & ~prev_q;
endmodule

// File: rtl/tap_freq_meter.sv
// rtl/tap_freq_meter.sv - gated edge counter on a selectable divider tap
// TAP_FREQ_METER_AUTO_EN: restart from DONE straight into ARM for back-to-back windows
import tap_freq_meter_pkg::*;

module tap_freq_meter (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       tap_in,
  tap_freq_meter_if.slave  bus
);
  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             arm_q, arm_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;
  logic             tap_bit;
  logic             rise;

  // In IDLE the live select feeds the synchronizer so ARM flushes the new tap, not the old one
  assign tap_bit = tap_in[(state_q == IDLE) ? bus.sel : sel_q];

  tap_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (tap_bit),
    .rise (rise)
  );

`ifdef TAP_FREQ_METER_AUTO_EN
  logic [3:0] gate_q, gate_d;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    win_d      = win_q;
    arm_d      = arm_q;
    edge_cnt_d = edge_cnt_q;
    count_d    = count_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
`ifdef TAP_FREQ_METER_AUTO_EN
    gate_d     = gate_q;
`endif
    cnt_nxt    = edge_cnt_q;
    sat_nxt    = sat_q;
    if (rise) begin
      if (edge_cnt_q == {CNT_W{1'b1}}) sat_nxt = 1'b1;
      else                             cnt_nxt = edge_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d      = bus.sel;
          win_d      = win_reload(bus.gate_len);
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          ovf_d      = 1'b0;
          arm_d      = 1'b0;
`ifdef TAP_FREQ_METER_AUTO_EN
          gate_d     = bus.gate_len;
`endif
          state_d    = ARM;
        end
      end
      ARM: begin
        arm_d = 1'b1;
        if (arm_q) state_d = MEASURE;
      end
      MEASURE: begin
        edge_cnt_d = cnt_nxt;
        sat_d      = sat_nxt;
        if (win_q == '0) begin
          count_d = cnt_nxt;
          ovf_d   = sat_nxt;
          state_d = DONE;
        end else begin
          win_d = win_q - 1'b1;
        end
      end
      DONE: begin
`ifdef TAP_FREQ_METER_AUTO_EN
        win_d      = win_reload(gate_q);
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        arm_d      = 1'b0;
        state_d    = ARM;
`else
        state_d    = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      win_q      <= '0;
      arm_q      <= 1'b0;
      edge_cnt_q <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      win_q      <= win_d;
      arm_q      <= arm_d;
      edge_cnt_q <= edge_cnt_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef TAP_FREQ_METER_AUTO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gate_q <= '0;
    else        gate_q <= gate_d;
  end
`endif

  assign bus.busy  = (state_q == ARM) || (state_q == MEASURE);
  assign bus.done  = (state_q == DONE);
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
endmodule
